mem_arbiter: RTL and testbench

- Shares the single off-chip memory request port between the instruction-cache refill path and the data-cache refill/writeback path of the MIPS150 core.
- Accepts one line-sized transaction at a time from either cache, issues it to memory as a fixed-length burst, and steers returned read beats back to the owner.
- Arbitrates round-robin when both caches request at once, so neither starves while the core is stalled on a miss.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst-oriented memory port between the
// icache refill path and the dcache refill/writeback path.
module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_req_ready_o,
  output logic              ic_rdata_valid_o,
  output logic [31:0]       ic_rdata_o,
  input  logic              dc_req_valid_i,
  input  logic              dc_req_rnw_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  output logic              dc_req_ready_o,
  input  logic [31:0]       dc_wdata_i,
  output logic              dc_wdata_ready_o,
  output logic              dc_rdata_valid_o,
  output logic [31:0]       dc_rdata_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rnw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  output logic              mem_wdata_valid_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_wdata_ready_i,
  input  logic              mem_rdata_valid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  // state | meaning
  // IDLE  | waiting for a request, grants in this cycle
  // CMD   | command held to memory until accepted
  // RDATA | forwarding read beats to the owner
  // WDATA | streaming dcache write beats to memory

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_e;

  state_e             state_q, state_d;
  logic               owner_dc_q, owner_dc_d;
  logic               rnw_q, rnw_d;
  logic               last_dc_q, last_dc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_dc, grant_ic;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      rnw_q      <= 1'b0;
      last_dc_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      rnw_q      <= rnw_d;
      last_dc_q  <= last_dc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_dc_d        = owner_dc_q;
    rnw_d             = rnw_q;
    last_dc_d         = last_dc_q;
    addr_d            = addr_q;
    cnt_d             = cnt_q;
    grant_dc          = 1'b0;
    grant_ic          = 1'b0;
    ic_req_ready_o    = 1'b0;
    ic_rdata_valid_o  = 1'b0;
    ic_rdata_o        = '0;
    dc_req_ready_o    = 1'b0;
    dc_wdata_ready_o  = 1'b0;
    dc_rdata_valid_o  = 1'b0;
    dc_rdata_o        = '0;
    mem_req_valid_o   = 1'b0;
    mem_req_rnw_o     = 1'b0;
    mem_req_addr_o    = '0;
    mem_wdata_valid_o = 1'b0;
    mem_wdata_o       = '0;
    busy_o            = 1'b0;

    // Outputs stay quiet during the reset cycle, even mid-transaction.
    if (!rst_i) begin
      busy_o = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          grant_dc = dc_req_valid_i && (!ic_req_valid_i || !last_dc_q);
          grant_ic = ic_req_valid_i && !grant_dc;
          if (grant_dc) begin
            dc_req_ready_o = 1'b1;
            owner_dc_d     = 1'b1;
            addr_d         = dc_req_addr_i;
            rnw_d          = dc_req_rnw_i;
            last_dc_d      = 1'b1;
            state_d        = CMD;
          end else if (grant_ic) begin
            ic_req_ready_o = 1'b1;
            owner_dc_d     = 1'b0;
            addr_d         = ic_req_addr_i;
            rnw_d          = 1'b1;
            last_dc_d      = 1'b0;
            state_d        = CMD;
          end
        end
        CMD: begin
          mem_req_valid_o = 1'b1;
          mem_req_rnw_o   = rnw_q;
          mem_req_addr_o  = addr_q;
          if (mem_req_ready_i) begin
            cnt_d   = '0;
            state_d = rnw_q ? RDATA : WDATA;
          end
        end
        RDATA: begin
          if (mem_rdata_valid_i) begin
            if (owner_dc_q) begin
              dc_rdata_valid_o = 1'b1;
              dc_rdata_o       = mem_rdata_i;
            end else begin
              ic_rdata_valid_o = 1'b1;
              ic_rdata_o       = mem_rdata_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_d = IDLE;
          end
        end
        WDATA: begin
          mem_wdata_valid_o = 1'b1;
          mem_wdata_o       = dc_wdata_i;
          dc_wdata_ready_o  = mem_wdata_ready_i;
          if (mem_wdata_ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; expectations come from a
// transaction-level round-robin model and the bench's own memory/cache stimulus.
module tb_mem_arbiter;

  localparam int BL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ic_req_valid_i, ic_req_ready_o, ic_rdata_valid_o;
  logic [31:0] ic_req_addr_i, ic_rdata_o;
  logic        dc_req_valid_i, dc_req_rnw_i, dc_req_ready_o;
  logic [31:0] dc_req_addr_i, dc_wdata_i, dc_rdata_o;
  logic        dc_wdata_ready_o, dc_rdata_valid_o;
  logic        mem_req_valid_o, mem_req_rnw_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_wdata_valid_o, mem_wdata_ready_i, mem_rdata_valid_i;
  logic        busy_o;

  mem_arbiter #(.BURST_LEN(BL), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
    .ic_req_ready_o(ic_req_ready_o), .ic_rdata_valid_o(ic_rdata_valid_o),
    .ic_rdata_o(ic_rdata_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_rnw_i(dc_req_rnw_i),
    .dc_req_addr_i(dc_req_addr_i), .dc_req_ready_o(dc_req_ready_o),
    .dc_wdata_i(dc_wdata_i), .dc_wdata_ready_o(dc_wdata_ready_o),
    .dc_rdata_valid_o(dc_rdata_valid_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_rnw_o(mem_req_rnw_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_wdata_valid_o(mem_wdata_valid_o), .mem_wdata_o(mem_wdata_o),
    .mem_wdata_ready_i(mem_wdata_ready_i),
    .mem_rdata_valid_i(mem_rdata_valid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // model state: pending requests and who won the last grant
  bit          m_last_dc;
  bit          ic_pend, dc_pend, dc_rnw;
  logic [31:0] ic_a, dc_a;
  logic [31:0] rbeats [BL];
  logic [31:0] wbeats [BL];
  bit          obs_dc [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic any_out();
    return |{ic_req_ready_o, ic_rdata_valid_o, ic_rdata_o, dc_req_ready_o,
             dc_wdata_ready_o, dc_rdata_valid_o, dc_rdata_o, mem_req_valid_o,
             mem_req_rnw_o, mem_req_addr_o, mem_wdata_valid_o, mem_wdata_o, busy_o};
  endfunction

  // Runs one transaction starting in an IDLE cycle at posedge+1. A read stops
  // early after abort_after beats when abort_after >= 0.
  task automatic do_txn(input int stall, input int pat, input int abort_after);
    bit w_dc, er, v;
    logic [31:0] ea;
    int b, cyc;
    ic_req_valid_i = ic_pend; ic_req_addr_i = ic_a;
    dc_req_valid_i = dc_pend; dc_req_addr_i = dc_a; dc_req_rnw_i = dc_rnw;
    mem_req_ready_i = 0; mem_rdata_valid_i = 0; mem_wdata_ready_i = 0;
    #4;
    w_dc = dc_pend && (!ic_pend || !m_last_dc);
    check("busy_at_grant", busy_o, 0);
    check("ic_req_ready", ic_req_ready_o, !w_dc);
    check("dc_req_ready", dc_req_ready_o, w_dc);
    obs_dc.push_back(dc_req_ready_o);
    ea = w_dc ? dc_a : ic_a;
    er = w_dc ? dc_rnw : 1'b1;
    m_last_dc = w_dc;
    if (w_dc) dc_pend = 0; else ic_pend = 0;
    tick();
    if (w_dc) dc_req_valid_i = 0; else ic_req_valid_i = 0;
    for (int s = 0; s <= stall; s++) begin
      mem_req_ready_i   = (s == stall);
      mem_rdata_valid_i = 1'($urandom_range(0, 1));
      mem_rdata_i       = $urandom;
      #4;
      check("cmd_valid", mem_req_valid_o, 1);
      check("cmd_addr", mem_req_addr_o, ea);
      check("cmd_rnw", mem_req_rnw_o, er);
      check("cmd_busy", busy_o, 1);
      check("cmd_no_beat", {ic_rdata_valid_o, dc_rdata_valid_o, ic_req_ready_o, dc_req_ready_o}, 0);
      tick();
    end
    mem_req_ready_i = 0; mem_rdata_valid_i = 0;
    b = 0; cyc = 0;
    while (b < BL && b != abort_after) begin
      if (pat == 0 || cyc >= 8) v = 1;
      else if (pat == 2) v = (cyc % 2 == 0);
      else v = 1'($urandom_range(0, 1));
      if (er) begin
        mem_rdata_valid_i = v;
        mem_rdata_i = v ? rbeats[b] : $urandom;
        #4;
        check("ic_rvalid", ic_rdata_valid_o, v && !w_dc);
        check("dc_rvalid", dc_rdata_valid_o, v && w_dc);
        if (v) check("rdata", w_dc ? dc_rdata_o : ic_rdata_o, rbeats[b]);
        check("rd_no_wvalid", mem_wdata_valid_o, 0);
      end else begin
        dc_wdata_i = wbeats[b];
        mem_wdata_ready_i = v;
        mem_rdata_valid_i = 1'($urandom_range(0, 1));
        #4;
        check("wvalid", mem_wdata_valid_o, 1);
        check("wdata", mem_wdata_o, wbeats[b]);
        check("dc_wready", dc_wdata_ready_o, v);
        check("wr_no_rvalid", {ic_rdata_valid_o, dc_rdata_valid_o}, 0);
      end
      check("beat_busy", busy_o, 1);
      if (v) b++;
      cyc++;
      tick();
      mem_rdata_valid_i = 0; mem_wdata_ready_i = 0;
    end
  endtask

  task automatic idle_check(input string tag);
    ic_req_valid_i = 0; dc_req_valid_i = 0;
    #4;
    check(tag, any_out(), 0);
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1;
    ic_req_valid_i = 1; ic_req_addr_i = 32'h100; dc_req_valid_i = 1;
    dc_req_rnw_i = 0; dc_req_addr_i = 32'h200; dc_wdata_i = 0;
    mem_req_ready_i = 0; mem_wdata_ready_i = 0;
    mem_rdata_valid_i = 0; mem_rdata_i = 0;
    tick(); tick();
    #4;
    check("reset_outputs", any_out(), 0);
    tick();
    rst_i = 0;
    m_last_dc = 0; ic_pend = 0; dc_pend = 0;
    idle_check("idle_after_reset");
  endtask

  initial begin
    bit rr_exp [4];
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    ic_a = 0; dc_a = 0; dc_rnw = 1;
    do_reset();

    // single icache read
    ic_pend = 1; ic_a = 32'h1000;
    for (int i = 0; i < BL; i++) rbeats[i] = 32'hA0 + i;
    do_txn(0, 0, -1);
    idle_check("ic_read_done");

    // simultaneous requests out of reset: dcache first, icache right after
    do_reset();
    obs_dc.delete();
    ic_pend = 1; ic_a = 32'h2000; dc_pend = 1; dc_a = 32'h3000; dc_rnw = 1;
    for (int i = 0; i < BL; i++) rbeats[i] = 32'hB0 + i;
    do_txn(0, 0, -1);
    for (int i = 0; i < BL; i++) rbeats[i] = 32'hC0 + i;
    do_txn(0, 0, -1);
    check("tie_first_dc", obs_dc[0], 1);
    check("tie_second_ic", obs_dc[1], 0);
    idle_check("tie_done");

    // round-robin with both caches requesting continuously
    do_reset();
    obs_dc.delete();
    ic_pend = 1; ic_a = 32'h7000; dc_pend = 1; dc_a = 32'h8000; dc_rnw = 1;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < BL; i++) rbeats[i] = $urandom;
      do_txn(0, 1, -1);
      ic_pend = 1; dc_pend = 1;
    end
    for (int t = 0; t < 4; t++) check("rr_order", obs_dc[t], rr_exp[t]);
    ic_pend = 0; dc_pend = 0;
    idle_check("rr_done");

    // dcache write with alternating memory backpressure
    dc_pend = 1; dc_a = 32'h4000; dc_rnw = 0;
    for (int i = 0; i < BL; i++) wbeats[i] = 32'h11 + i;
    do_txn(0, 2, -1);
    idle_check("write_done");

    // command stall for five cycles
    ic_pend = 1; ic_a = 32'h9000;
    for (int i = 0; i < BL; i++) rbeats[i] = $urandom;
    do_txn(5, 0, -1);
    idle_check("stall_done");

    // reset in RDATA after two beats, stray beat afterwards, then a clean read
    ic_pend = 1; ic_a = 32'h5000;
    for (int i = 0; i < BL; i++) rbeats[i] = 32'hD0 + i;
    do_txn(0, 0, 2);
    rst_i = 1;
    mem_rdata_valid_i = 1; mem_rdata_i = 32'hDEAD;
    #4;
    check("rst_cycle_quiet", any_out(), 0);
    tick();
    rst_i = 0;
    m_last_dc = 0;
    mem_rdata_valid_i = 1; mem_rdata_i = 32'hBEEF;
    #4;
    check("post_rst_quiet", any_out(), 0);
    tick();
    mem_rdata_valid_i = 0;
    ic_pend = 1; ic_a = 32'h6000;
    for (int i = 0; i < BL; i++) rbeats[i] = 32'hE0 + i;
    do_txn(0, 0, -1);
    idle_check("post_rst_read_done");

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      if (!ic_pend && $urandom_range(0, 1) == 1) begin
        ic_pend = 1; ic_a = $urandom & 32'hFFFF_FFF0;
      end
      if (!dc_pend && $urandom_range(0, 1) == 1) begin
        dc_pend = 1; dc_a = $urandom & 32'hFFFF_FFF0; dc_rnw = 1'($urandom_range(0, 1));
      end
      if (!ic_pend && !dc_pend) begin
        ic_pend = 1; ic_a = $urandom & 32'hFFFF_FFF0;
      end
      for (int i = 0; i < BL; i++) begin
        rbeats[i] = $urandom;
        wbeats[i] = $urandom;
      end
      do_txn($urandom_range(0, 3), 1, -1);
    end
    while (ic_pend || dc_pend) begin
      for (int i = 0; i < BL; i++) begin
        rbeats[i] = $urandom;
        wbeats[i] = $urandom;
      end
      do_txn(0, 1, -1);
    end
    idle_check("random_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
